// File: rtl/cpu_defines.sv
// Shared CPU definitions: AXI size codes
// and uncached write buffer FSM states.
package cpu_defines;

  localparam logic [2:0] AXI_SIZE_BYTE = 3'd0;
  localparam logic [2:0] AXI_SIZE_HALF = 3'd1;
  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    WBUF_IDLE = 2'd0,
    WBUF_ADDR = 2'd1,
    WBUF_RESP = 2'd2
  } wbuf_state_e;

endpackage

// File: rtl/wbuf_fifo.sv
// Store queue for the uncached write buffer:
// entry storage, pointers, occupancy vector.
module wbuf_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [ADDR_W-1:0]             push_addr_i,
  input  logic [1:0]                    push_size_i,
  input  logic [31:0]                   push_wdata_i,
  input  logic [3:0]                    push_wstrb_i,
  input  logic                          pop_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [ADDR_W-1:0]             head_addr_o,
  output logic [1:0]                    head_size_o,
  output logic [31:0]                   head_wdata_o,
  output logic [3:0]                    head_wstrb_o,
  output logic [DEPTH-1:0]              ent_valid_o,
  output logic [DEPTH*(ADDR_W-2)-1:0]   ent_waddr_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     count;
  logic [AW-1:0]     off;
  logic              do_push, do_pop;

  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [1:0]        size_q  [DEPTH];
  logic [31:0]       wdata_q [DEPTH];
  logic [3:0]        wstrb_q [DEPTH];

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_addr_o  = addr_q[rd_ptr_q[AW-1:0]];
  assign head_size_o  = size_q[rd_ptr_q[AW-1:0]];
  assign head_wdata_o = wdata_q[rd_ptr_q[AW-1:0]];
  assign head_wstrb_o = wstrb_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state; wrap is natural modulo 2*DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[wr_ptr_q[AW-1:0]]  <= push_addr_i;
      size_q[wr_ptr_q[AW-1:0]]  <= push_size_i;
      wdata_q[wr_ptr_q[AW-1:0]] <= push_wdata_i;
      wstrb_q[wr_ptr_q[AW-1:0]] <= push_wstrb_i;
    end
  end

  // Slot i is occupied when its distance from the head is below count.
  always_comb begin
    count       = wr_ptr_q - rd_ptr_q;
    off         = '0;
    ent_valid_o = '0;
    ent_waddr_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = AW'(i) - rd_ptr_q[AW-1:0];
      ent_valid_o[i] = ({1'b0, off} < count);
      ent_waddr_o[i*(ADDR_W-2) +: (ADDR_W-2)] = addr_q[i][ADDR_W-1:2];
    end
  end

endmodule

// File: rtl/uncached_wbuf.sv
// Posted write buffer for uncached stores:
// drains entries as single-beat AXI writes.
module uncached_wbuf
  import cpu_defines::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  input  logic [ADDR_W-1:0] rd_check_addr,
  output logic              rd_conflict,
  output logic              empty,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  wbuf_state_e state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        pop;
  logic        fifo_full, fifo_empty;
  logic [1:0]  head_size;
  logic [DEPTH-1:0]            ent_valid;
  logic [DEPTH*(ADDR_W-2)-1:0] ent_waddr;
  logic        unused_lsb;

  wbuf_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (req_valid && req_ready),
    .push_addr_i  (req_addr),
    .push_size_i  (req_size),
    .push_wdata_i (req_wdata),
    .push_wstrb_i (req_wstrb),
    .pop_i        (pop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_addr_o  (awaddr),
    .head_size_o  (head_size),
    .head_wdata_o (wdata),
    .head_wstrb_o (wstrb),
    .ent_valid_o  (ent_valid),
    .ent_waddr_o  (ent_waddr)
  );

  assign req_ready  = !fifo_full;
  assign empty      = fifo_empty && (state_q == WBUF_IDLE);
  assign awlen      = 8'd0;
  assign awsize     = {1'b0, head_size};
  assign wlast      = 1'b1;
  assign unused_lsb = ^rd_check_addr[1:0];

  // Drain FSM state and per-entry handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WBUF_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // AW and W complete independently; response pops the head.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      WBUF_IDLE: begin
        if (!fifo_empty) state_d = WBUF_ADDR;
      end
      WBUF_ADDR: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WBUF_RESP;
      end
      WBUF_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          pop       = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WBUF_IDLE;
        end
      end
      default: state_d = WBUF_IDLE;
    endcase
  end

  // Any occupied entry (head included) with the same word address.
  always_comb begin
    rd_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] &&
          ent_waddr[i*(ADDR_W-2) +: (ADDR_W-2)] == rd_check_addr[ADDR_W-1:2])
        rd_conflict = 1'b1;
    end
  end

endmodule
